// File: rtl/receiver_pkg.sv
// Shared definitions for the receiver end of the Request/Ack word link.
package receiver_pkg;

  localparam int RX_DATA_W    = 16;
  localparam int RX_DEPTH     = 16;
  // Words per burst; has to match the sender's transfer count.
  localparam int RX_BURST_LEN = 16;

  // Handshake FSM state encoding.
  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/receiver_rx_fifo.sv
// Synchronous FIFO buffering received words for the local consumer.
// Pushes are refused while full and pops are ignored while empty. The
// empty and full flags come straight from flops, and they are computed
// from the next occupancy value.
module rx_fifo
  import receiver_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W,
  parameter int DEPTH  = RX_DEPTH
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rvalid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [CW-1:0]     count_nxt;

  // Qualify the requests against the current flags and work out the next occupancy.
  always_comb begin
    do_push   = push && !full;
    do_pop    = pop && !empty;
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // Word storage. It needs no reset because the pointers and the count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy, flags and the registered read port.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= do_pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rdata  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/receiver.sv
// Responder end of the Request/Ack link. It captures one word per four-phase
// handshake into a FIFO, holds off the sender while the FIFO is full, and
// pulses BurstDone when the last word of each burst is captured.
module receiver
  import receiver_pkg::*;
#(
  parameter int DATA_W    = RX_DATA_W,
  parameter int DEPTH     = RX_DEPTH,
  parameter int BURST_LEN = RX_BURST_LEN
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   Request,
  input  logic [DATA_W-1:0]      DataIn,
  output logic                   Ack,
  input  logic                   RdEn,
  output logic [DATA_W-1:0]      RdData,
  output logic                   RdValid,
  output logic                   Empty,
  output logic                   Full,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   BurstDone
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  rx_state_t     state;
  rx_state_t     state_nxt;
  logic          push;
  logic [BW-1:0] burst_cnt;

  // Handshake state register. Reset drops Ack immediately because Ack decodes this flop.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture only when there is room, then wait in ACK until Request falls.
  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE: if (Request && !Full) state_nxt = RX_ACK;
      RX_ACK:  if (!Request)         state_nxt = RX_IDLE;
      default: state_nxt = RX_IDLE;
    endcase
  end

  // Push on the capturing edge. Ack is the ACK state bit itself, so it stays glitch-free.
  always_comb begin
    push = (state == RX_IDLE) && Request && !Full;
    Ack  = (state == RX_ACK);
  end

  // Burst position counter. It wraps on the last word and flags that word one cycle later.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      burst_cnt <= '0;
      BurstDone <= 1'b0;
    end else begin
      BurstDone <= 1'b0;
      if (push) begin
        if (burst_cnt == BW'(BURST_LEN - 1)) begin
          burst_cnt <= '0;
          BurstDone <= 1'b1;
        end else begin
          burst_cnt <= burst_cnt + BW'(1);
        end
      end
    end
  end

  rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .Reset  (Reset),
    .push   (push),
    .pop    (RdEn),
    .wdata  (DataIn),
    .rdata  (RdData),
    .rvalid (RdValid),
    .empty  (Empty),
    .full   (Full),
    .count  (Count)
  );

endmodule

// File: tb/tb_receiver.sv
// Bench for the receiver. A small sender model drives handshakes and queues
// each offered word. Reads pop the queue and compare it against RdData.
module tb_receiver;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Request;
  logic [15:0] DataIn;
  logic        Ack;
  logic        RdEn;
  logic [15:0] RdData;
  logic        RdValid;
  logic        Empty;
  logic        Full;
  logic [4:0]  Count;
  logic        BurstDone;

  int          checks = 0;
  int          failures = 0;
  int          burst_pulses = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_rd = 16'h0000;

  receiver dut (
    .clk       (clk),
    .Reset     (Reset),
    .Request   (Request),
    .DataIn    (DataIn),
    .Ack       (Ack),
    .RdEn      (RdEn),
    .RdData    (RdData),
    .RdValid   (RdValid),
    .Empty     (Empty),
    .Full      (Full),
    .Count     (Count),
    .BurstDone (BurstDone)
  );

  always #5 clk = ~clk;

  // Count the cycles in which BurstDone is high. A pulse wider than one cycle counts more than once.
  always @(negedge clk) begin
    if (BurstDone === 1'b1) burst_pulses++;
  end

  // Sender model: offer a word, hold Request for 1+extra cycles after Ack, then release it.
  task automatic send_word(input logic [15:0] w, input int extra, output int ack_cycles);
    int n;
    @(negedge clk);
    Request = 1'b1;
    DataIn  = w;
    exp_q.push_back(w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (Ack !== 1'b1 && n < 50);
    checks++;
    if (Ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ack_rise word=%h Ack=%b expected 1", w, Ack);
    end
    ack_cycles = 0;
    repeat (1 + extra) begin
      if (Ack === 1'b1) ack_cycles++;
      @(negedge clk);
    end
    Request = 1'b0;
    n = 0;
    while (Ack === 1'b1 && n < 50) begin
      ack_cycles++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (Ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ack_fall word=%h Ack=%b expected 0", w, Ack);
    end
  endtask

  // Consumer: pulse RdEn and compare the popped word against the oldest queued word.
  task automatic read_word(input string name);
    logic [15:0] exp;
    @(negedge clk);
    RdEn = 1'b1;
    @(negedge clk);
    RdEn = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (RdValid !== 1'b1 || RdData !== exp) begin
      failures++;
      $display("[TB] FAIL %s RdValid=%b RdData=%h expected RdValid=1 RdData=%h", name, RdValid, RdData, exp);
    end
    last_rd = exp;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Request = 1'b0; RdEn = 1'b0; DataIn = 16'h0000;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (Ack !== 1'b0 || RdData !== 16'h0 || RdValid !== 1'b0 || BurstDone !== 1'b0 ||
        Count !== 5'd0 || Empty !== 1'b1 || Full !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state Ack=%b RdData=%h RdValid=%b BurstDone=%b Count=%0d Empty=%b Full=%b expected 0,0000,0,0,0,1,0",
               Ack, RdData, RdValid, BurstDone, Count, Empty, Full);
    end
  endtask

  task automatic test_single();
    int ac;
    send_word(16'hA5A5, 0, ac);
    checks++;
    if (ac != 2) begin
      failures++;
      $display("[TB] FAIL single_ack_width got=%0d cycles expected 2", ac);
    end
    checks++;
    if (Count !== 5'd1 || Empty !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_level Count=%0d Empty=%b expected 1,0", Count, Empty);
    end
    read_word("single_read");
    @(negedge clk);
    checks++;
    if (RdValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rdvalid_pulse RdValid=%b expected 0", RdValid);
    end
  endtask

  // Sixteen words from base. BurstDone must stay quiet for 15 words and pulse once on the 16th.
  task automatic burst_of_16(input logic [15:0] base, input string name);
    int ac;
    int p0;
    p0 = burst_pulses;
    for (int i = 0; i < 15; i++) send_word(base + 16'(i), 0, ac);
    checks++;
    if (burst_pulses != p0) begin
      failures++;
      $display("[TB] FAIL %s_early pulses=%0d expected 0 before 16th word", name, burst_pulses - p0);
    end
    send_word(base + 16'd15, 0, ac);
    checks++;
    if (burst_pulses != p0 + 1) begin
      failures++;
      $display("[TB] FAIL %s_done pulses=%0d expected 1", name, burst_pulses - p0);
    end
    checks++;
    if (Full !== 1'b1 || Count !== 5'd16) begin
      failures++;
      $display("[TB] FAIL %s_full Full=%b Count=%0d expected 1,16", name, Full, Count);
    end
  endtask

  task automatic test_full_burst();
    test_reset();
    burst_of_16(16'h0000, "burst");
  endtask

  task automatic test_back_pressure();
    int  n;
    bit  bad;
    logic [15:0] exp;
    @(negedge clk);
    Request = 1'b1;
    DataIn  = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (Ack !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || Count !== 5'd16) begin
      failures++;
      $display("[TB] FAIL stall Ack_seen_high=%0d Count=%0d expected 0,16", bad, Count);
    end
    RdEn = 1'b1;
    @(negedge clk);
    RdEn = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (RdValid !== 1'b1 || RdData !== exp || Full !== 1'b0 || Ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_pop RdValid=%b RdData=%h Full=%b Ack=%b expected 1,%h,0,0", RdValid, RdData, Full, Ack, exp);
    end
    @(negedge clk);
    checks++;
    if (Ack !== 1'b1 || Count !== 5'd16) begin
      failures++;
      $display("[TB] FAIL bp_accept Ack=%b Count=%0d expected 1,16", Ack, Count);
    end
    @(negedge clk);
    Request = 1'b0;
    n = 0;
    while (Ack === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 16; i++) read_word("drain");
    checks++;
    if (Empty !== 1'b1 || Count !== 5'd0) begin
      failures++;
      $display("[TB] FAIL drained Empty=%b Count=%0d expected 1,0", Empty, Count);
    end
  endtask

  task automatic test_long_request();
    int ac;
    logic [4:0] c0;
    c0 = Count;
    send_word(16'h1234, 5, ac);
    checks++;
    if (ac != 7 || Count !== c0 + 5'd1) begin
      failures++;
      $display("[TB] FAIL long_req ack_cycles=%0d Count=%0d expected 7,%0d", ac, Count, c0 + 5'd1);
    end
    read_word("long_req_read");
  endtask

  task automatic test_pop_empty_and_simultaneous();
    int ac;
    int n;
    logic [15:0] exp;
    @(negedge clk);
    RdEn = 1'b1;
    @(negedge clk);
    RdEn = 1'b0;
    checks++;
    if (RdValid !== 1'b0 || Count !== 5'd0 || RdData !== last_rd) begin
      failures++;
      $display("[TB] FAIL pop_empty RdValid=%b Count=%0d RdData=%h expected 0,0,%h", RdValid, Count, RdData, last_rd);
    end
    send_word(16'h0101, 0, ac);
    send_word(16'h0202, 0, ac);
    send_word(16'h0303, 0, ac);
    @(negedge clk);
    Request = 1'b1;
    DataIn  = 16'h7777;
    RdEn    = 1'b1;
    exp = exp_q.pop_front();
    exp_q.push_back(16'h7777);
    @(negedge clk);
    RdEn = 1'b0;
    checks++;
    if (Ack !== 1'b1 || Count !== 5'd3 || RdValid !== 1'b1 || RdData !== exp) begin
      failures++;
      $display("[TB] FAIL push_pop Ack=%b Count=%0d RdValid=%b RdData=%h expected 1,3,1,%h", Ack, Count, RdValid, RdData, exp);
    end
    @(negedge clk);
    Request = 1'b0;
    n = 0;
    while (Ack === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset_mid_handshake();
    int ac;
    int n;
    send_word(16'h4444, 0, ac);
    @(negedge clk);
    Request = 1'b1;
    DataIn  = 16'h5555;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (Ack !== 1'b1 && n < 50);
    checks++;
    if (Ack !== 1'b1 || Count !== 5'd5) begin
      failures++;
      $display("[TB] FAIL mid_setup Ack=%b Count=%0d expected 1,5", Ack, Count);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (Ack !== 1'b0 || Count !== 5'd0 || Empty !== 1'b1 || Full !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset Ack=%b Count=%0d Empty=%b Full=%b expected 0,0,1,0", Ack, Count, Empty, Full);
    end
    @(negedge clk);
    Request = 1'b0;
    Reset   = 1'b0;
    exp_q.delete();
    burst_of_16(16'h0100, "post_reset_burst");
    read_word("post_reset_read");
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_burst();
    test_back_pressure();
    test_long_request();
    test_pop_empty_and_simultaneous();
    test_reset_mid_handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- Far end of the Request/Ack 16-bit word link: the responder for the sender FSM.
- Captures each word offered under Request and acknowledges it with a four-phase handshake.
- Buffers words in a 16-deep FIFO for the local consumer.
- Counts words into 16-word bursts and flags each completed burst.

Parameters:
DATA_W, 16, width of DataIn / RdData
DEPTH, 16, FIFO depth in words (power of two)
BURST_LEN, 16, words per burst; must equal the sender's transfer count

Ports:
clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Request  input  1  sender holds word valid on DataIn while high
DataIn  input  DATA_W  word from sender, stable while Request=1
Ack  output  1  word captured; held until Request falls
RdEn  input  1  consumer pop request
RdData  output  DATA_W  popped word, registered
RdValid  output  1  RdData valid this cycle (one-cycle pulse per pop)
Empty  output  1  FIFO holds no words
Full  output  1  FIFO holds DEPTH words
Count  output  $clog2(DEPTH)+1  words currently in FIFO
BurstDone  output  1  one-cycle pulse when the BURST_LEN-th word of a burst is captured

Behaviour:
- Reset values: Ack=0, RdData=0, RdValid=0, BurstDone=0, Count=0, Empty=1, Full=0, word counter=0, state=IDLE.
- Reset mid-operation: Ack drops immediately, FIFO contents discarded, burst counter cleared. The sender recovers through its own reset.
- Single clock domain. Request is sampled directly, with no synchronizer. All outputs are registered.
- FSM states: IDLE, ACK.
- IDLE, Request=1 and Full=0 at an edge:
  - DataIn is pushed at that edge.
  - Ack goes to 1 at that edge.
  - State moves to ACK.
- IDLE, Request=1 and Full=1: no push, Ack stays 0, state holds. The sender stalls in its REQUEST state. This is the flow control; no word is ever dropped.
- IDLE, Request=0: state holds.
- ACK, Request=1: Ack holds at 1, no further push. One word is captured per handshake regardless of Request duration.
- ACK, Request=0: Ack goes to 0 at that edge, state moves to IDLE.
- Nominal timing with the sender: Ack is high for 2 cycles. The receiver is back in IDLE before the sender's next REQUEST.
- Burst counter:
  - Range 0..BURST_LEN-1, increments on each push.
  - The push made while the counter is BURST_LEN-1 asserts BurstDone for exactly 1 cycle (the cycle after that edge) and wraps the counter to 0.
- Read side:
  - RdEn=1 with Empty=0 pops at the edge. RdData is loaded and RdValid=1 the following cycle.
  - RdEn with Empty=1 is ignored: RdValid=0, RdData holds its last value.
- Simultaneous push and pop in the same cycle: both occur and Count is unchanged.
- Full is evaluated before the pop. A push is refused in a cycle where Full=1, even if RdEn=1 in that cycle. The word is then accepted the next cycle.
- Count saturates naturally at DEPTH and never exceeds it.
- Read and write pointers wrap modulo DEPTH.

Decomposition:
- Shared package holds:
  - FSM state encoding: RX_IDLE, RX_ACK.
  - DATA_W default.
  - BURST_LEN default, shared with the sender's transfer count of 16.
- Natural sub-module rx_fifo: synchronous FIFO with parameters DATA_W and DEPTH.
  - Ports: push, pop, wdata, rdata, rvalid, empty, full, count.
  - The receiver top keeps the handshake FSM and the burst counter.

Test Plan:
- Reset then a single handshake:
  - Stimulus: Request=1 with DataIn=16'hA5A5; drop Request one cycle after Ack.
  - Response: Ack high 2 cycles; Count=1; Empty=0.
  - Stimulus: pulse RdEn. Response: RdValid=1 and RdData=16'hA5A5 one cycle later.
- Full burst against the sender model:
  - Stimulus: 16 words 16'h0000..16'h000F.
  - Response: BurstDone pulses once, on the 16th capture. Full=1, Count=16.
  - Stimulus: drain by RdEn. Response: words out in order 0..F, then Empty=1.
- Back-pressure:
  - Stimulus: FIFO full, Request=1 held 10 cycles. Response: Ack stays 0, Count stays 16.
  - Stimulus: one RdEn. Response: Ack rises on the edge after Full deasserts; the word is stored.
- Long Request:
  - Stimulus: Request held high 5 cycles after Ack.
  - Response: exactly one push; Ack stays 1 until Request=0.
- Pop on empty and simultaneous push/pop:
  - Stimulus: RdEn on empty FIFO. Response: RdValid=0, Count=0.
  - Stimulus: with Count=3, RdEn coincident with a push. Response: Count stays 3.
- Reset mid-handshake:
  - Stimulus: assert Reset while Ack=1 and Count=5.
  - Response: Ack=0 immediately (before the next clk edge); Count=0, Empty=1.
  - Next burst: BurstDone fires after 16 new words.
